// File: rtl/segm7_rx_monitor.sv
// rtl/segm7_rx_monitor.sv - 74HC595 COM/SEG chain receiver that decodes 7-segment frames into hex digits
//
// Emulates the COM and SEG shift/latch chains seen on the board pins. It
// rebuilds each latched byte LSB-first and decodes the segment byte into a
// hex nibble. The nibble is stored in the slot named by the single zero bit
// of the active-low COM byte. Digits and status are readable over a small
// AXI-style register port.
//
// Optional macro: SEGM7_RX_SYNC_EN
//   defined   -> two-flop synchronizer on every serial pin (pins asynchronous to S_AXI_ACLK)
//   undefined -> pins sampled directly (driver must share S_AXI_ACLK)
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARSTN              clock, asynchronous active-low reset
//   COM_SER/COM_SRCLK/COM_RCLK           COM chain data, shift clock, latch clock
//   SEG_SER/SEG_SRCLK/SEG_RCLK           SEG chain data, shift clock, latch clock
//   S_AXI_AWADDR/AWVALID/WVALID/WDATA    register write (write to 0x0004 clears status)
//   S_AXI_ARADDR, reg_data_out           combinational register read
//   digits_out                           nibble k = decoded slot k
//   frame_pulse                          one-cycle pulse when the last slot is updated
module segm7_rx_monitor #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int NUM_DIGITS         = 6
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARSTN,
    input  logic                          COM_SER,
    input  logic                          COM_SRCLK,
    input  logic                          COM_RCLK,
    input  logic                          SEG_SER,
    input  logic                          SEG_SRCLK,
    input  logic                          SEG_RCLK,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    input  logic                          S_AXI_WVALID,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg_data_out,
    output logic [31:0]                   digits_out,
    output logic                          frame_pulse
);

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DIGITS = C_S_AXI_ADDR_WIDTH'(16'h0000);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STATUS = C_S_AXI_ADDR_WIDTH'(16'h0004);
    localparam logic [2:0]                    LAST_POS    = 3'(NUM_DIGITS);

    // Pin vector layout
    localparam int P_COM_SER   = 0;
    localparam int P_COM_SRCLK = 1;
    localparam int P_COM_RCLK  = 2;
    localparam int P_SEG_SER   = 3;
    localparam int P_SEG_SRCLK = 4;
    localparam int P_SEG_RCLK  = 5;

    // Clock-line vector layout (edge detector)
    localparam int C_COM_SRCLK = 0;
    localparam int C_COM_RCLK  = 1;
    localparam int C_SEG_SRCLK = 2;
    localparam int C_SEG_RCLK  = 3;

    // Write data carries no information: any write to the status address clears it.
    logic unused_wdata;
    assign unused_wdata = ^S_AXI_WDATA;

    logic [5:0] pins;
    logic [5:0] pins_s;
    assign pins = {SEG_RCLK, SEG_SRCLK, SEG_SER, COM_RCLK, COM_SRCLK, COM_SER};

`ifdef SEGM7_RX_SYNC_EN
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = pins;
        sync2_d = sync1_q;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            sync1_q <= 6'b0;
            sync2_q <= 6'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pins_s = sync2_q;
`else
    assign pins_s = pins;
`endif

    // All six lines pass through cur_q so data and clocks stay aligned; only
    // the four clock lines need the extra prev_q stage for edge detection.
    logic [5:0]  cur_q, cur_d;
    logic [3:0]  prev_q, prev_d;
    logic [7:0]  com_sr_q, com_sr_d;
    logic [7:0]  seg_sr_q, seg_sr_d;
    logic [7:0]  seg_latch_q, seg_latch_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        seg_err_q, seg_err_d;
    logic        com_err_q, com_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_pulse_q, frame_pulse_d;

    logic [3:0]  cur_clk;
    logic [3:0]  rise;
    logic [7:0]  seg_val;
    logic [7:0]  com_zeros;
    logic        one_zero;
    logic [2:0]  slot_pos;
    logic [2:0]  slot_idx;
    logic        com_ok;
    logic [4:0]  dec;
    logic        clear;

    // Returns {valid, nibble}; bit7 (decimal point) set is never a valid digit.
    function automatic logic [4:0] seg_decode(input logic [7:0] b);
        case (b)
            8'h7E:   return {1'b1, 4'h0};
            8'h30:   return {1'b1, 4'h1};
            8'h6D:   return {1'b1, 4'h2};
            8'h79:   return {1'b1, 4'h3};
            8'h33:   return {1'b1, 4'h4};
            8'h5B:   return {1'b1, 4'h5};
            8'h5F:   return {1'b1, 4'h6};
            8'h72:   return {1'b1, 4'h7};
            8'h7F:   return {1'b1, 4'h8};
            8'h7B:   return {1'b1, 4'h9};
            8'h77:   return {1'b1, 4'hA};
            8'h1F:   return {1'b1, 4'hB};
            8'h4E:   return {1'b1, 4'hC};
            8'h3D:   return {1'b1, 4'hD};
            8'h4F:   return {1'b1, 4'hE};
            8'h47:   return {1'b1, 4'hF};
            default: return 5'b0;
        endcase
    endfunction

    always_comb begin
        cur_d   = pins_s;
        cur_clk = {cur_q[P_SEG_RCLK], cur_q[P_SEG_SRCLK], cur_q[P_COM_RCLK], cur_q[P_COM_SRCLK]};
        prev_d  = cur_clk;
        rise    = cur_clk & ~prev_q;

        com_sr_d      = com_sr_q;
        seg_sr_d      = seg_sr_q;
        seg_latch_d   = seg_latch_q;
        digits_d      = digits_q;
        seg_err_d     = seg_err_q;
        com_err_d     = com_err_q;
        frame_valid_d = frame_valid_q;
        frame_cnt_d   = frame_cnt_q;
        frame_pulse_d = 1'b0;

        if (rise[C_COM_SRCLK]) com_sr_d = {cur_q[P_COM_SER], com_sr_q[7:1]};
        if (rise[C_SEG_SRCLK]) seg_sr_d = {cur_q[P_SEG_SER], seg_sr_q[7:1]};
        // Latches take the pre-shift register value when both clocks rise together.
        if (rise[C_SEG_RCLK])  seg_latch_d = seg_sr_q;
        seg_val = rise[C_SEG_RCLK] ? seg_sr_q : seg_latch_q;

        // The COM byte is consumed in the cycle it is latched, so only its
        // classification is kept, not the byte itself.
        com_zeros = ~com_sr_q;
        one_zero  = (com_zeros != 8'h00) && ((com_zeros & (com_zeros - 8'd1)) == 8'h00);
        slot_pos  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (com_zeros[i]) slot_pos = 3'(i);
        end
        com_ok   = one_zero && (slot_pos != 3'd0) && (slot_pos <= LAST_POS);
        slot_idx = slot_pos - 3'd1;
        dec      = seg_decode(seg_val);

        // Clear is applied first so a coincident event leaves its flag/count set.
        clear = S_AXI_AWVALID && S_AXI_WVALID && (S_AXI_AWADDR == ADDR_STATUS);
        if (clear) begin
            frame_cnt_d   = 8'd0;
            seg_err_d     = 1'b0;
            com_err_d     = 1'b0;
            frame_valid_d = 1'b0;
        end

        if (rise[C_COM_RCLK]) begin
            if (com_ok) begin
                if (dec[4]) digits_d[{slot_idx, 2'b00} +: 4] = dec[3:0];
                else        seg_err_d = 1'b1;
                if (slot_pos == LAST_POS) begin
                    frame_cnt_d   = frame_cnt_d + 8'd1;
                    frame_pulse_d = 1'b1;
                    frame_valid_d = 1'b1;
                end
            end else begin
                com_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            cur_q         <= 6'b0;
            prev_q        <= 4'b0;
            com_sr_q      <= 8'hFF;
            seg_sr_q      <= 8'h00;
            seg_latch_q   <= 8'h00;
            digits_q      <= 32'h0;
            frame_cnt_q   <= 8'd0;
            seg_err_q     <= 1'b0;
            com_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_pulse_q <= 1'b0;
        end else begin
            cur_q         <= cur_d;
            prev_q        <= prev_d;
            com_sr_q      <= com_sr_d;
            seg_sr_q      <= seg_sr_d;
            seg_latch_q   <= seg_latch_d;
            digits_q      <= digits_d;
            frame_cnt_q   <= frame_cnt_d;
            seg_err_q     <= seg_err_d;
            com_err_q     <= com_err_d;
            frame_valid_q <= frame_valid_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    assign digits_out  = digits_q;
    assign frame_pulse = frame_pulse_q;

    always_comb begin
        reg_data_out = '0;
        if (S_AXI_ARADDR == ADDR_DIGITS) begin
            reg_data_out = C_S_AXI_DATA_WIDTH'(digits_q);
        end else if (S_AXI_ARADDR == ADDR_STATUS) begin
            reg_data_out = C_S_AXI_DATA_WIDTH'({21'b0, frame_valid_q, com_err_q, seg_err_q, frame_cnt_q});
        end
    end

endmodule

// File: tb/tb_segm7_rx_monitor.sv
// tb/tb_segm7_rx_monitor.sv - directed self-checking bench for segm7_rx_monitor
module tb_segm7_rx_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        com_ser = 1'b0, com_srclk = 1'b0, com_rclk = 1'b0;
    logic        seg_ser = 1'b0, seg_srclk = 1'b0, seg_rclk = 1'b0;
    logic [15:0] awaddr = 16'h0;
    logic        awvalid = 1'b0, wvalid = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [15:0] araddr = 16'h0;
    logic [31:0] reg_data_out;
    logic [31:0] digits_out;
    logic        frame_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    logic [7:0] seg_code [16];

    segm7_rx_monitor #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(16),
        .NUM_DIGITS(6)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARSTN(rst_n),
        .COM_SER(com_ser),
        .COM_SRCLK(com_srclk),
        .COM_RCLK(com_rclk),
        .SEG_SER(seg_ser),
        .SEG_SRCLK(seg_srclk),
        .SEG_RCLK(seg_rclk),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WDATA(wdata),
        .S_AXI_ARADDR(araddr),
        .reg_data_out(reg_data_out),
        .digits_out(digits_out),
        .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_pulse) pulse_cnt++;

    task automatic shift_bytes(input logic [7:0] seg, input logic [7:0] com);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seg_ser = seg[i]; com_ser = com[i];
            seg_srclk = 1'b0; com_srclk = 1'b0;
            @(negedge clk);
            seg_srclk = 1'b1; com_srclk = 1'b1;
        end
        @(negedge clk);
        seg_srclk = 1'b0; com_srclk = 1'b0;
    endtask

    task automatic send_digit(input logic [7:0] seg, input logic [7:0] com);
        shift_bytes(seg, com);
        @(negedge clk);
        seg_rclk = 1'b1; com_rclk = 1'b1;
        @(negedge clk);
        seg_rclk = 1'b0; com_rclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [23:0] value);
        for (int s = 0; s < 6; s++) begin
            logic [7:0] com;
            logic [3:0] nib;
            com = ~(8'h01 << (s + 1));
            nib = value[s*4 +: 4];
            send_digit(seg_code[nib], com);
        end
    endtask

    task automatic reg_write(input logic [15:0] addr);
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] addr, output logic [31:0] data);
        araddr = addr;
        #1;
        data = reg_data_out;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        read_reg(16'h0000, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_reg0 got %h exp %h", r, 32'h0); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", r, 32'h0); end
        checks++; if (digits_out !== 32'h0) begin errors++; $display("FAIL reset_digits got %h exp %h", digits_out, 32'h0); end
        checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", frame_pulse); end
    endtask

    task automatic test_decode_slot1;
        logic [31:0] r;
        send_digit(8'h4E, 8'hFB);
        checks++; if (digits_out !== 32'h0000_00C0) begin errors++; $display("FAIL slot1_digits got %h exp %h", digits_out, 32'hC0); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL slot1_status got %h exp %h", r, 32'h0); end
    endtask

    task automatic test_seg_err;
        logic [31:0] r;
        send_digit(8'h80, 8'hFD);
        checks++; if (digits_out !== 32'h0000_00C0) begin errors++; $display("FAIL segerr_digits got %h exp %h", digits_out, 32'hC0); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h100) begin errors++; $display("FAIL segerr_status got %h exp %h", r, 32'h100); end
        reg_write(16'h0000);
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h100) begin errors++; $display("FAIL segerr_other_write got %h exp %h", r, 32'h100); end
        reg_write(16'h0004);
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL segerr_clear got %h exp %h", r, 32'h0); end
    endtask

    task automatic test_com_err;
        logic [31:0] r;
        send_digit(8'h30, 8'hF5);
        checks++; if (digits_out !== 32'h0000_00C0) begin errors++; $display("FAIL comerr_digits got %h exp %h", digits_out, 32'hC0); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h200) begin errors++; $display("FAIL comerr_status got %h exp %h", r, 32'h200); end
        send_digit(8'h30, 8'hFE);
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h200) begin errors++; $display("FAIL comerr_bit0 got %h exp %h", r, 32'h200); end
        checks++; if (digits_out !== 32'h0000_00C0) begin errors++; $display("FAIL comerr_bit0_digits got %h exp %h", digits_out, 32'hC0); end
        reg_write(16'h0004);
    endtask

    task automatic test_frame;
        logic [31:0] r;
        int p0;
        p0 = pulse_cnt;
        send_frame(24'h123456);
        checks++; if (digits_out !== 32'h0012_3456) begin errors++; $display("FAIL frame_digits got %h exp %h", digits_out, 32'h00123456); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL frame_pulses got %0d exp 1", pulse_cnt - p0); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h401) begin errors++; $display("FAIL frame_status1 got %h exp %h", r, 32'h401); end
        send_frame(24'h123456);
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h402) begin errors++; $display("FAIL frame_status2 got %h exp %h", r, 32'h402); end
        checks++; if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL frame_pulses2 got %0d exp 2", pulse_cnt - p0); end
        read_reg(16'h0000, r);
        checks++; if (r !== 32'h0012_3456) begin errors++; $display("FAIL frame_reg0 got %h exp %h", r, 32'h00123456); end
        read_reg(16'h0008, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL other_addr got %h exp %h", r, 32'h0); end
    endtask

    task automatic test_latency;
        logic [31:0] r;
        shift_bytes(8'h72, 8'hBF);
        @(negedge clk);
        seg_rclk = 1'b1; com_rclk = 1'b1;
        @(negedge clk);
        checks++; if (digits_out !== 32'h0012_3456 || frame_pulse !== 1'b0) begin errors++; $display("FAIL latency_early digits %h pulse %b exp %h 0", digits_out, frame_pulse, 32'h00123456); end
        seg_rclk = 1'b0; com_rclk = 1'b0;
        @(negedge clk);
        checks++; if (digits_out !== 32'h0072_3456 || frame_pulse !== 1'b1) begin errors++; $display("FAIL latency_update digits %h pulse %b exp %h 1", digits_out, frame_pulse, 32'h00723456); end
        @(negedge clk);
        checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL latency_pulse_width got %b exp 0", frame_pulse); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h403) begin errors++; $display("FAIL latency_status got %h exp %h", r, 32'h403); end
    endtask

    task automatic test_clear_coincident;
        logic [31:0] r;
        shift_bytes(8'h7E, 8'hBF);
        @(negedge clk);
        seg_rclk = 1'b1; com_rclk = 1'b1;
        @(negedge clk);
        awaddr = 16'h0004; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        seg_rclk = 1'b0; com_rclk = 1'b0;
        repeat (2) @(negedge clk);
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h401) begin errors++; $display("FAIL clear_coincident got %h exp %h", r, 32'h401); end
        checks++; if (digits_out !== 32'h0002_3456) begin errors++; $display("FAIL clear_coincident_digits got %h exp %h", digits_out, 32'h00023456); end
    endtask

    task automatic test_wrap;
        logic [31:0] r;
        int p0;
        reg_write(16'h0004);
        p0 = pulse_cnt;
        for (int n = 0; n < 256; n++) send_digit(8'h7E, 8'hBF);
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h400) begin errors++; $display("FAIL wrap_status got %h exp %h", r, 32'h400); end
        checks++; if (pulse_cnt - p0 !== 256) begin errors++; $display("FAIL wrap_pulses got %0d exp 256", pulse_cnt - p0); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seg_ser = 1'b1; seg_srclk = 1'b0;
            @(negedge clk);
            seg_srclk = 1'b1;
        end
        @(negedge clk);
        seg_srclk = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (digits_out !== 32'h0 || frame_pulse !== 1'b0) begin errors++; $display("FAIL midreset_outputs digits %h pulse %b exp 0 0", digits_out, frame_pulse); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_status got %h exp %h", r, 32'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(24'hABCDEF);
        checks++; if (digits_out !== 32'h00AB_CDEF) begin errors++; $display("FAIL midreset_frame got %h exp %h", digits_out, 32'h00ABCDEF); end
        read_reg(16'h0004, r);
        checks++; if (r !== 32'h401) begin errors++; $display("FAIL midreset_frame_status got %h exp %h", r, 32'h401); end
    endtask

    initial begin
        seg_code[0]  = 8'h7E; seg_code[1]  = 8'h30; seg_code[2]  = 8'h6D; seg_code[3]  = 8'h79;
        seg_code[4]  = 8'h33; seg_code[5]  = 8'h5B; seg_code[6]  = 8'h5F; seg_code[7]  = 8'h72;
        seg_code[8]  = 8'h7F; seg_code[9]  = 8'h7B; seg_code[10] = 8'h77; seg_code[11] = 8'h1F;
        seg_code[12] = 8'h4E; seg_code[13] = 8'h3D; seg_code[14] = 8'h4F; seg_code[15] = 8'h47;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_decode_slot1;
        test_seg_err;
        test_com_err;
        test_frame;
        test_latency;
        test_clear_coincident;
        test_wrap;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
